// File: rtl/mem_seq_arbiter.sv
// rtl/mem_seq_arbiter.sv - sequential byte-port arbiter between instruction fetch and load/store
// Words are moved one byte per cycle over a RAM with one cycle of read latency.
module mem_seq_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, XFER, TAIL} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_owner_mem;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_last_a;
  logic [2:0]        r_n;
  logic [2:0]        r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_acc;
  logic [31:0]       r_if_inst;
  logic [31:0]       r_mem_rdata;
  logic              r_if_done;
  logic              r_mem_done;

  logic              w_guard;
  logic              w_accept_mem;
  logic              w_accept_if;
  logic              w_abort;
  logic              w_last;
  logic [ADDR_W-1:0] w_cur_a;
  logic [1:0]        w_cap_idx;
  logic [2:0]        w_req_n;
  logic [31:0]       w_acc_next;

  // A done cycle is a guard cycle: the requester needs it to drop its request.
  assign w_guard      = r_if_done | r_mem_done;
  assign w_accept_mem = (r_state == IDLE) && !w_guard && mem_req;
  assign w_accept_if  = (r_state == IDLE) && !w_guard && !mem_req && if_req && !if_flush;
  assign w_abort      = (r_state != IDLE) && !r_owner_mem && if_flush;
  assign w_last       = (r_idx == r_n - 3'd1);
  assign w_cur_a      = r_base + ADDR_W'(r_idx);
  assign w_cap_idx    = 2'(r_idx - 3'd1);
  assign w_req_n      = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{w_cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ram_a        = r_last_a;
    ram_wr       = 1'b0;
    ram_dout     = r_wdata[{r_idx[1:0], 3'b000} +: 8];
    if (rdy) begin
      case (r_state)
        IDLE: if (w_accept_mem || w_accept_if) w_state_next = XFER;
        XFER: begin
          ram_a  = w_cur_a;
          ram_wr = r_we;
          if (w_abort) w_state_next = IDLE;
          else if (w_last) w_state_next = r_we ? IDLE : TAIL;
        end
        TAIL:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // While frozen, ram_a keeps the last issued address so ram_din still holds the pending byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_mem <= 1'b0;
      r_we        <= 1'b0;
      r_base      <= '0;
      r_last_a    <= '0;
      r_n         <= 3'd0;
      r_idx       <= 3'd0;
      r_wdata     <= 32'd0;
      r_acc       <= 32'd0;
      r_if_inst   <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
    end else if (rdy) begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept_mem) begin
            r_owner_mem <= 1'b1;
            r_base      <= mem_addr;
            r_n         <= w_req_n;
            r_we        <= mem_we;
            r_wdata     <= mem_wdata;
            r_idx       <= 3'd0;
            r_acc       <= 32'd0;
          end else if (w_accept_if) begin
            r_owner_mem <= 1'b0;
            r_base      <= if_addr;
            r_n         <= 3'd4;
            r_we        <= 1'b0;
            r_idx       <= 3'd0;
            r_acc       <= 32'd0;
          end
        end
        XFER: begin
          r_last_a <= w_cur_a;
          if (!w_abort) begin
            r_idx <= r_idx + 3'd1;
            if (!r_we && r_idx != 3'd0) r_acc <= w_acc_next;
            if (r_we && w_last) r_mem_done <= 1'b1;
          end
        end
        TAIL: begin
          if (!w_abort) begin
            r_acc <= w_acc_next;
            if (r_owner_mem) begin
              r_mem_rdata <= w_acc_next;
              r_mem_done  <= 1'b1;
            end else begin
              r_if_inst <= w_acc_next;
              r_if_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign if_done   = r_if_done;
  assign if_inst   = r_if_inst;
  assign mem_done  = r_mem_done;
  assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_seq_arbiter.sv
// tb/tb_mem_seq_arbiter.sv - scoreboard bench for mem_seq_arbiter with a 1-cycle-latency RAM model
module tb_mem_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  mem_seq_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {logic [31:0] data; int at; logic chk_data;} done_t;
  typedef struct {logic [31:0] a; logic [7:0] d; int at;} wr_t;
  done_t if_q[$];
  done_t mem_q[$];
  wr_t   wr_q[$];
  done_t mon_e;
  wr_t   mon_w;

  // RAM model: fixed preload plus a write overlay indexed by the low 16 address bits
  logic [7:0] wmem [0:65535];
  logic       wval [0:65535];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (wval[a[15:0]] === 1'b1) return wmem[a[15:0]];
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0102: return 8'h10;
      32'h0000_0200: return 8'h37;
      32'h0000_0201: return 8'h12;
      32'h0000_0300: return 8'h7E;
      32'h0000_0400: return 8'h01;
      32'h0000_0401: return 8'h02;
      32'h0000_0402: return 8'h03;
      32'h0000_0403: return 8'h04;
      32'hFFFF_FFFE: return 8'h11;
      32'hFFFF_FFFF: return 8'hA5;
      32'h0000_0000: return 8'h22;
      32'h0000_0001: return 8'h33;
      default:       return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int k = 0; k < 65536; k++) wval[k] <= 1'b0;
    end else if (ram_wr === 1'b1) begin
      wval[ram_a[15:0]] <= 1'b1;
      wmem[ram_a[15:0]] <= ram_dout;
    end
    ram_din <= rd_byte(ram_a);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_if(input int at, input logic [31:0] d);
    done_t e;
    e.data = d; e.at = at; e.chk_data = 1'b1;
    if_q.push_back(e);
  endtask

  task automatic exp_mem(input int at, input logic [31:0] d, input logic cd);
    done_t e;
    e.data = d; e.at = at; e.chk_data = cd;
    mem_q.push_back(e);
  endtask

  task automatic exp_wr(input int at, input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d; w.at = at;
    wr_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (cyc > 2) begin
      if (if_done === 1'b1 && rdy) begin
        if (if_q.size() == 0) begin
          total++; bad++;
          $display("FAIL if_done_unexpected at cycle %0d: got pulse expected none", cyc);
        end else begin
          mon_e = if_q.pop_front();
          chk("if_done_cycle", cyc, mon_e.at);
          if (mon_e.chk_data) chk("if_inst", if_inst, mon_e.data);
        end
      end
      if (mem_done === 1'b1 && rdy) begin
        if (mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_done_unexpected at cycle %0d: got pulse expected none", cyc);
        end else begin
          mon_e = mem_q.pop_front();
          chk("mem_done_cycle", cyc, mon_e.at);
          if (mon_e.chk_data) chk("mem_rdata", mem_rdata, mon_e.data);
        end
      end
      if (ram_wr === 1'b1) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ram_wr_unexpected at cycle %0d: got write %h<=%h expected none", cyc, ram_a, ram_dout);
        end else begin
          mon_w = wr_q.pop_front();
          chk("ram_wr_cycle", cyc, mon_w.at);
          chk("ram_wr_addr", ram_a, mon_w.a);
          chk("ram_wr_data", {24'd0, ram_dout}, {24'd0, mon_w.d});
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  initial begin
    int t;
    at_neg(3);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    goto(4);
    rst = 1'b0;

    // word fetch at 0x100
    goto(6);
    t = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    exp_if(t + 6, 32'h0010_0513);
    for (int k = 1; k <= 4; k++) begin
      at_neg(t + k);
      chk("fetch_ram_a", ram_a, 32'h100 + 32'(k - 1));
    end
    goto(t + 7);
    if_req = 1'b0;

    // half store, unaligned
    goto(t + 8);
    t = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1; mem_addr = 32'h2001; mem_wdata = 32'hAABB_CCDD;
    exp_wr(t + 1, 32'h2001, 8'hDD);
    exp_wr(t + 2, 32'h2002, 8'hCC);
    exp_mem(t + 3, 32'd0, 1'b0);
    goto(t + 4);
    mem_req = 1'b0; mem_we = 1'b0;

    // simultaneous requests: byte load wins, fetch follows after the guard cycle
    goto(t + 6);
    t = cyc;
    mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h100;
    exp_mem(t + 3, 32'h0000_007E, 1'b1);
    exp_if(t + 10, 32'h0010_0513);
    goto(t + 4);
    mem_req = 1'b0;
    at_neg(t + 5);
    chk("arb_if_ram_a", ram_a, 32'h100);
    goto(t + 11);
    if_req = 1'b0;

    // flush in the second XFER cycle, then refetch at 0x200
    goto(t + 13);
    t = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    goto(t + 2);
    if_flush = 1'b1; if_addr = 32'h200;
    goto(t + 3);
    if_flush = 1'b0;
    exp_if(t + 9, 32'h0000_1237);
    at_neg(t + 3);
    chk("flush_inst_hold", if_inst, 32'h0010_0513);
    at_neg(t + 4);
    chk("refetch_ram_a", ram_a, 32'h200);
    goto(t + 10);
    if_req = 1'b0;

    // byte load at top of memory, then a word load that wraps
    goto(t + 12);
    t = cyc;
    mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'hFFFF_FFFF;
    exp_mem(t + 3, 32'h0000_00A5, 1'b1);
    at_neg(t + 1);
    chk("wrap_byte_ram_a", ram_a, 32'hFFFF_FFFF);
    goto(t + 4);
    mem_len = 2'd2; mem_addr = 32'hFFFF_FFFE;
    t = t + 4;
    exp_mem(t + 6, 32'h3322_A511, 1'b1);
    at_neg(t + 3);
    chk("wrap_ram_a_0", ram_a, 32'h0);
    at_neg(t + 4);
    chk("wrap_ram_a_1", ram_a, 32'h1);
    goto(t + 7);
    mem_req = 1'b0;

    // mem_len 3 behaves as a word
    goto(t + 9);
    t = cyc;
    mem_req = 1'b1; mem_len = 2'd3; mem_addr = 32'h100;
    exp_mem(t + 6, 32'h0010_0513, 1'b1);
    goto(t + 7);
    mem_req = 1'b0;

    // rdy low for three cycles mid word load
    goto(t + 9);
    t = cyc;
    mem_req = 1'b1; mem_len = 2'd2; mem_addr = 32'h400;
    exp_mem(t + 9, 32'h0403_0201, 1'b1);
    goto(t + 3);
    rdy = 1'b0;
    at_neg(t + 4);
    chk("stall_ram_a_hold", ram_a, 32'h401);
    goto(t + 6);
    rdy = 1'b1;
    goto(t + 10);
    mem_req = 1'b0;

    // reset in the middle of a word store
    goto(t + 12);
    t = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h500; mem_wdata = 32'h1122_3344;
    exp_wr(t + 1, 32'h500, 8'h44);
    exp_wr(t + 2, 32'h501, 8'h33);
    goto(t + 2);
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    at_neg(t + 3);
    chk("mid_rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("mid_rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("mid_rst_if_done", {31'd0, if_done}, 32'd0);
    chk("mid_rst_mem_rdata", mem_rdata, 32'd0);
    chk("mid_rst_if_inst", if_inst, 32'd0);
    chk("mid_rst_ram_a", ram_a, 32'd0);
    goto(t + 4);
    rst = 1'b0;
    goto(t + 5);
    t = cyc;
    mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'h501;
    exp_mem(t + 3, 32'h0000_0033, 1'b1);
    at_neg(t + 1);
    chk("post_rst_ram_a", ram_a, 32'h501);
    goto(t + 4);
    mem_req = 1'b0;

    goto(t + 10);
    chk("if_q_drained", if_q.size(), 32'd0);
    chk("mem_q_drained", mem_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_seq_arbiter.md
# mem_seq_arbiter

Sequential replacement for the combinational IF/MEM memory mux. Arbitrates the single byte-wide RAM port between instruction fetch and the load/store unit. Each granted request runs as a multi-cycle transaction: 32-bit little-endian words are assembled from, or split into, byte accesses, and completion is signalled with a one-cycle done pulse. RAM read latency is fixed at 1 cycle: data for the address driven in cycle k appears on ram_din in cycle k+1.

## Interface
- ADDR_W, 32, address width for the requester ports and the RAM port
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes the block
- if_req  in  1  fetch request (4 bytes)
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  abort the pending or in-flight fetch (branch taken)
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched instruction
- mem_req  in  1  load/store request
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 2/3 = word
- mem_addr  in  ADDR_W  byte address, no alignment required
- mem_wdata  in  32  store data, low bytes used
- mem_done  out  1  one-cycle pulse; mem_rdata valid on loads
- mem_rdata  out  32  load data, zero-extended
- ram_a  out  ADDR_W  RAM byte address
- ram_dout  out  8  RAM write data
- ram_wr  out  1  RAM write strobe
- ram_din  in  8  RAM read data

## Operation
- States: IDLE, XFER, TAIL.
- IDLE:
  - Requests are sampled only here, and not in a cycle where either done output is high.
  - mem_req has priority over if_req.
  - An if_req is not accepted in a cycle where if_flush is high.
  - On accept, latch owner, base address, N bytes (1/2/4; a fetch is always 4), we and wdata. Clear byte index i and the data accumulator. Go to XFER.
- XFER: ram_a = base + i (ADDR_W wrap-around), i increments.
  - Store: ram_wr = 1 and ram_dout = wdata[8i+7:8i]. After byte N-1, go to IDLE and set mem_done for the next cycle.
  - Load/fetch: ram_wr = 0. From the second XFER cycle on, ram_din is captured into byte i-1 of the accumulator. After issuing byte N-1, go to TAIL.
- TAIL: capture the last byte into byte N-1, go to IDLE, set the owner's done for the next cycle. rdata/inst update in the same cycle as done and hold until the next completion.
- if_flush while the owner is IF (XFER or TAIL): abort at the next edge and return to IDLE. No if_done is issued and if_inst is unchanged. Stores are never aborted; if_flush is ignored when the owner is MEM.
- rdy low: state, i, accumulator and outputs hold; ram_wr forced 0. ram_a holds so that ram_din stays valid for the pending capture. The done pulse is stretched, not lost.
- Reset (from any state, mid-transaction included): state IDLE, all outputs 0, accumulator 0. No done is issued for an aborted transaction.

## Timing
- Request high in IDLE cycle t (accepted):
  - read of N bytes: ram_a in t+1..t+N, captures at end of t+2..t+N+1, done high in t+N+2 (word fetch: done at t+6);
  - store of N bytes: ram_wr in t+1..t+N, done in t+N+1.
- Done is a registered pulse, high for exactly 1 cycle while rdy=1.
- Back-to-back: the cycle holding done is a guard cycle, so the next accept is at the earliest 1 cycle after done. A registered requester drops req on seeing done without a re-issue.
- Simultaneous mem_req and if_req in an accept cycle: MEM granted. IF stays pending with no starvation guarantee, matching the pipeline stall policy.

## Test plan
- Fetch if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103 in t+1..t+4, if_done at t+6, if_inst=0x00100513.
- Store half, mem_addr=0x2001, wdata=0xAABBCCDD -> ram_wr in t+1,t+2 at 0x2001/0x2002 with data 0xDD/0xCC, mem_done at t+3, no third write.
- mem_req and if_req together -> MEM load served first. IF accepted the cycle after mem_done's guard cycle; IF completes with correct data.
- if_flush in the second XFER cycle of a fetch -> IDLE next edge, no if_done. A new fetch at 0x200 is accepted the following cycle and returns data from 0x200.
- Byte load at 0xFFFFFFFF, then a word load at 0xFFFFFFFE -> second access wraps to ram_a 0x0 and 0x1; mem_rdata zero-extended.
- rdy low for 3 cycles mid-word-load, then rst mid-store -> load data intact and done delayed by 3 cycles. After rst: ram_wr=0, done outputs 0, state IDLE next cycle.
